spi_master_cfg: RTL and testbench
=================================

// Module: spi_master_cfg
// PURPOSE
// - Parametrised SPI master. Runtime-selectable mode (CPOL/CPHA), bit order, SCLK divider and slave select.
// - Full-duplex shift of DATA_W bits per transfer under a start/busy/done handshake, with optional abort.
// - Sits between the host register/bus logic and the SPI pins; drives NUM_SS active-low selects.
// PARAMETERS
// - DATA_W    8  bits per transfer (2..32)
// - NUM_SS    4  number of slave-select lines (1..16)
// - DIV_W     8  width of clk_div; SCLK half-period H = clk_div+1 clk cycles
// PORTS
// - clk        in   1             system clock, single domain, all logic on posedge
// - reset      in   1             asynchronous, active-low reset
// - start      in   1             request transfer; accepted only when busy=0
// - abort      in   1             terminate current transfer
// - tx_data    in   DATA_W        word to send, latched on accept
// - cpol       in   1             SCLK idle level, latched on accept
// - cpha       in   1             0: sample on leading edge; 1: sample on trailing edge
// - lsb_first  in   1             bit order, latched on accept
// - slave_sel  in   $clog2(NUM_SS) target slave, latched on accept
// - clk_div    in   DIV_W         divider, latched on accept
// - miso       in   1             serial in
// - sclk       out  1             serial clock
// - mosi       out  1             serial out
// - ss_n       out  NUM_SS        active-low selects, at most one low
// - busy       out  1             transfer in progress
// - done       out  1             1-cycle pulse, rx_data valid
// - rx_data    out  DATA_W        last received word, held until next done
// BEHAVIOUR
// - Reset: sclk=0, mosi=0, ss_n=all 1, busy=0, done=0, rx_data=0, FSM=IDLE, cfg regs=0.
// - Accept: start=1 & busy=0 -> latch tx_data/cfg; next cycle busy=1, FSM=SETUP.
// - start while busy=1 ignored (no queueing).
// - FSM IDLE -> SETUP (H cycles) -> XFER (2*DATA_W half-periods of H) -> HOLD (H) -> IDLE.
// - SETUP: ss_n[slave_sel]=0, sclk=cpol.
//   - cpha=0: first bit on mosi for the whole of SETUP.
// - XFER: sclk toggles every H cycles; leading edge = transition away from cpol.
//   - cpha=0: sample miso on leading, shift mosi on trailing.
//   - cpha=1: shift mosi on leading, sample miso on trailing.
//   - Exactly DATA_W leading and DATA_W trailing edges; sclk returns to cpol at end of XFER.
// - Bit order: lsb_first=0 -> MSB out first, rx assembled MSB first; lsb_first=1 mirrors both.
// - HOLD: ss_n stays low; sclk=cpol. Exit -> ss_n all 1, busy=0, done=1, rx_data updated same cycle.
// - Latency: busy high for exactly (2*DATA_W+2)*H cycles.
// - Back-to-back: start in the done cycle is accepted (busy=0 there); ss_n deasserts >=1 cycle between words.
// - abort (any non-IDLE state): next cycle FSM=IDLE, busy=0, ss_n all 1, sclk=cpol.
//   - No done; rx_data unchanged.
// - abort in IDLE has no effect; abort with start in IDLE -> start wins.
// - slave_sel >= NUM_SS: transfer runs, all ss_n stay 1, done still pulses.
// - Inputs clk_div/cpol/cpha/tx_data changing mid-transfer have no effect.
// - Async reset mid-transfer: immediate return to reset values, no done.
// - mosi outside SETUP/XFER/HOLD: 0.
// STRUCTURE
// - Package spi_pkg: FSM state enum (IDLE, SETUP, XFER, HOLD) and mode constants MODE0..MODE3 = {cpol,cpha}.
// - Sub-module spi_sclk_div: DIV_W down-counter.
//   - Emits a 1-cycle tick every H cycles while enabled; reloads on enable rise.
//   - Top keeps FSM, edge counter ($clog2(2*DATA_W+1) bits), shift register, ss decode.
// TESTING
// - DATA_W=8, mode0, MSB first, div=1, tx=0xA5, miso=mosi loopback:
//   - rx_data=0xA5, done once, busy 36 cycles, 8 rising sclk edges.
// - Mode3, lsb_first=1, div=0, tx=0x3C, slave model returns 0x81 LSB first:
//   - rx_data=0x81, sclk idles 1, mosi bit sequence 0,0,1,1,1,1,0,0.
// - slave_sel=2, NUM_SS=4: ss_n=4'b1011 during busy, 4'b1111 otherwise.
//   - start pulsed mid-transfer -> ignored; only one done.
// - abort at cycle 10 of a div=1 transfer:
//   - Next cycle busy=0, ss_n=all 1, sclk=cpol, no done, rx_data holds previous 0xA5.
// - start asserted in done cycle with tx=0x5A:
//   - Second transfer follows, ss_n high for >=1 cycle, two dones, rx=0x5A.
// - reset low mid-XFER:
//   - All outputs to reset values asynchronously; a fresh start after release completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pkg                                                              |
// | Shared FSM state encoding and SPI mode constants for spi_master_cfg. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    // Mode encodings as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sclk_div                                                         |
// | Down-counter issuing a 1-cycle tick every div_i+1 cycles while       |
// | enabled; the count restarts from div_i on every enable rise.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_sclk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q;
    logic [DIV_W-1:0] cnt_cur;

    // First enabled cycle behaves as if the counter had just been loaded
    assign cnt_cur = (en_i && !en_q) ? div_i : cnt_q;
    assign tick_o  = en_i && (cnt_cur == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tick_o ? div_i : (cnt_cur - DIV_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master_cfg                                                       |
// | Runtime-configurable full-duplex SPI master with start/busy/done     |
// | handshake, abort and NUM_SS active-low slave selects.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    input  logic [SS_W-1:0]   slave_sel_i,
    input  logic [DIV_W-1:0]  clk_div_i,
    input  logic              miso_i,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic [NUM_SS-1:0] ss_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o
);

    localparam int              EC_W      = $clog2(2*DATA_W+1);
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2*DATA_W-1);

    spi_state_e        state_q, state_d;
    logic              tick;
    logic              accept;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [SS_W-1:0]   ss_q, ss_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [EC_W-1:0]   edge_q, edge_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
    logic              leading, shift_edge, sample_edge;
    logic [DATA_W-1:0] tx_src, tx_shifted;
    logic              tx_lsb, tx_bit;

    spi_sclk_div #(.DIV_W(DIV_W)) u_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (busy_o),
        .div_i  (div_q),
        .tick_o (tick)
    );

    assign accept = start_i && (state_q == ST_IDLE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_SETUP;
            ST_SETUP: if (abort_i) state_d = ST_IDLE;
                      else if (tick) state_d = ST_XFER;
            ST_XFER:  if (abort_i) state_d = ST_IDLE;
                      else if (tick && (edge_q == LAST_EDGE)) state_d = ST_HOLD;
            ST_HOLD:  if (abort_i || tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o    = (state_q != ST_IDLE);
        sclk_o    = sclk_q;
        mosi_o    = mosi_q;
        done_o    = done_q;
        rx_data_o = rx_data_q;
    end

    // Out-of-range selects match no line, so the transfer runs deselected
    for (genvar i = 0; i < NUM_SS; i++) begin : g_ss
        assign ss_n_o[i] = ~(busy_o && (ss_q == SS_W'(i)));
    end

    // Even edge index is a leading edge (sclk moving away from cpol)
    assign leading     = ~edge_q[0];
    assign shift_edge  = tick && (state_q == ST_XFER) && (cpha_q ? leading : ~leading);
    assign sample_edge = tick && (state_q == ST_XFER) && (cpha_q ? ~leading : leading);

    assign tx_src     = accept ? tx_data_i : tx_sh_q;
    assign tx_lsb     = accept ? lsb_first_i : lsb_q;
    assign tx_bit     = tx_lsb ? tx_src[0] : tx_src[DATA_W-1];
    assign tx_shifted = tx_lsb ? (tx_src >> 1) : (tx_src << 1);

    always_comb begin
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        ss_d      = ss_q;
        div_d     = div_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        if (accept) begin
            cpol_d  = cpol_i;
            cpha_d  = cpha_i;
            lsb_d   = lsb_first_i;
            ss_d    = slave_sel_i;
            div_d   = clk_div_i;
            rx_sh_d = '0;
            edge_d  = '0;
            sclk_d  = cpol_i;
            // cpha=0 presents the first bit for the whole of SETUP
            mosi_d  = cpha_i ? 1'b0 : tx_bit;
            tx_sh_d = cpha_i ? tx_data_i : tx_shifted;
        end else if (busy_o && abort_i) begin
            sclk_d = cpol_q;
            mosi_d = 1'b0;
        end else begin
            if (tick && (state_q == ST_XFER)) begin
                sclk_d = ~sclk_q;
                edge_d = edge_q + EC_W'(1);
            end
            if (shift_edge) begin
                mosi_d  = tx_bit;
                tx_sh_d = tx_shifted;
            end
            if (sample_edge) begin
                rx_sh_d = lsb_q ? {miso_i, rx_sh_q[DATA_W-1:1]}
                                : {rx_sh_q[DATA_W-2:0], miso_i};
            end
            if (tick && (state_q == ST_HOLD)) begin
                done_d    = 1'b1;
                rx_data_d = rx_sh_q;
                mosi_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            ss_q      <= '0;
            div_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            edge_q    <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            ss_q      <= ss_d;
            div_q     <= div_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            edge_q    <= edge_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_master_cfg                                                    |
// | Scenario bench for spi_master_cfg with an rx scoreboard.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_spi_master_cfg;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic [7:0] tx_data = '0;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic [1:0] slave_sel = '0;
    logic [7:0] clk_div = '0;
    logic       miso;
    logic       sclk, mosi, busy, done;
    logic [3:0] ss_n;
    logic [7:0] rx_data;

    bit         loopback = 1'b1;
    bit         slave_en = 1'b0;
    logic [7:0] slv_word = '0;
    logic       slv_miso = 1'b0;
    int         slv_idx = 0;

    int         n_checks = 0, n_fail = 0;
    logic [7:0] sb[$];

    int         st_busy, st_rise, st_done, st_ss_bad, st_nm;
    logic [7:0] st_mseq;
    logic       m_pol, m_pha;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : slv_miso;

    spi_master_cfg #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .tx_data_i(tx_data), .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb_first),
        .slave_sel_i(slave_sel), .clk_div_i(clk_div), .miso_i(miso),
        .sclk_o(sclk), .mosi_o(mosi), .ss_n_o(ss_n), .busy_o(busy),
        .done_o(done), .rx_data_o(rx_data)
    );

    // Slave shifting its word out LSB first on each leading (falling) edge
    always @(negedge sclk) begin
        if (slave_en && slv_idx < 8) begin
            slv_miso = slv_word[slv_idx];
            slv_idx++;
        end
    end

    // Scoreboard: every done pops one expected rx word
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: got rx=%02h, expected no done", rx_data);
            end else begin
                logic [7:0] exp;
                exp = sb.pop_front();
                if (rx_data !== exp) begin
                    n_fail++;
                    $display("FAIL sb_rx: got %02h expected %02h", rx_data, exp);
                end
            end
        end
    end

    task automatic start_xfer(input logic [7:0] tx, input logic [1:0] mode, input logic lsb,
                              input logic [1:0] sel, input logic [7:0] div);
        @(negedge clk);
        tx_data = tx; {cpol, cpha} = mode; lsb_first = lsb; slave_sel = sel; clk_div = div;
        m_pol = mode[1]; m_pha = mode[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Collects statistics over a bounded window; mosi is recorded at each sampling edge
    task automatic watch(input int max_cyc, input logic [3:0] exp_ss, input bit stop_on_done,
                         input int poke_at);
        logic prev;
        st_busy = 0; st_rise = 0; st_done = 0; st_ss_bad = 0; st_nm = 0; st_mseq = '0;
        prev = sclk;
        for (int i = 0; i < max_cyc; i++) begin
            if (poke_at >= 0) begin
                start = (i == poke_at);
                if (i == poke_at) tx_data = 8'hFF;
            end
            if (busy) st_busy++;
            if (sclk !== prev) begin
                if (sclk) st_rise++;
                if (sclk === (m_pha ? m_pol : ~m_pol)) begin
                    st_mseq = {st_mseq[6:0], mosi};
                    st_nm++;
                end
            end
            if (ss_n !== (busy ? exp_ss : 4'hF)) st_ss_bad++;
            if (done) begin
                st_done++;
                if (stop_on_done) break;
            end
            prev = sclk;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (sclk !== 1'b0)     begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        if (mosi !== 1'b0)     begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        if (ss_n !== 4'hF)     begin n_fail++; $display("FAIL reset_ss_n: got %b expected 1111", ss_n); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx: got %02h expected 00", rx_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mode0_loopback;
        loopback = 1'b1;
        sb.push_back(8'hA5);
        start_xfer(8'hA5, MODE0, 1'b0, 2'd0, 8'd1);
        watch(60, 4'b1110, 1'b0, -1);
        n_checks += 6;
        if (st_busy != 36)     begin n_fail++; $display("FAIL m0_busy_cycles: got %0d expected 36", st_busy); end
        if (st_rise != 8)      begin n_fail++; $display("FAIL m0_sclk_rises: got %0d expected 8", st_rise); end
        if (st_done != 1)      begin n_fail++; $display("FAIL m0_done_count: got %0d expected 1", st_done); end
        if (st_ss_bad != 0)    begin n_fail++; $display("FAIL m0_ss_n: got %0d bad cycles expected 0", st_ss_bad); end
        if (st_mseq !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi_seq: got %02h expected a5", st_mseq); end
        if (mosi !== 1'b0)     begin n_fail++; $display("FAIL m0_mosi_idle: got %b expected 0", mosi); end
    endtask

    task automatic test_mode3_lsb;
        loopback = 1'b0; slave_en = 1'b1; slv_idx = 0; slv_word = 8'h81;
        sb.push_back(8'h81);
        start_xfer(8'h3C, MODE3, 1'b1, 2'd0, 8'd0);
        watch(40, 4'b1110, 1'b0, -1);
        slave_en = 1'b0;
        n_checks += 5;
        if (st_busy != 18)     begin n_fail++; $display("FAIL m3_busy_cycles: got %0d expected 18", st_busy); end
        if (st_nm != 8)        begin n_fail++; $display("FAIL m3_sample_edges: got %0d expected 8", st_nm); end
        // Sample order 0,0,1,1,1,1,0,0
        if (st_mseq !== 8'b0011_1100) begin n_fail++; $display("FAIL m3_mosi_seq: got %08b expected 00111100", st_mseq); end
        if (sclk !== 1'b1)     begin n_fail++; $display("FAIL m3_sclk_idle: got %b expected 1", sclk); end
        if (st_rise != 8)      begin n_fail++; $display("FAIL m3_sclk_rises: got %0d expected 8", st_rise); end
        // LSB-first ordering with a non-palindromic word, mode1, div=2
        loopback = 1'b1;
        sb.push_back(8'h1E);
        start_xfer(8'h1E, MODE1, 1'b1, 2'd0, 8'd2);
        watch(80, 4'b1110, 1'b0, -1);
        n_checks += 2;
        if (st_mseq !== 8'h78) begin n_fail++; $display("FAIL m1_lsb_mosi_seq: got %02h expected 78", st_mseq); end
        if (st_busy != 54)     begin n_fail++; $display("FAIL m1_busy_cycles: got %0d expected 54", st_busy); end
    endtask

    task automatic test_slave_sel;
        loopback = 1'b1;
        sb.push_back(8'hA5);
        start_xfer(8'hA5, MODE0, 1'b0, 2'd2, 8'd1);
        watch(60, 4'b1011, 1'b0, 12);
        n_checks += 3;
        if (st_ss_bad != 0) begin n_fail++; $display("FAIL ss2_ss_n: got %0d bad cycles expected 0", st_ss_bad); end
        if (st_done != 1)   begin n_fail++; $display("FAIL ss2_done_count: got %0d expected 1", st_done); end
        if (st_busy != 36)  begin n_fail++; $display("FAIL ss2_busy_cycles: got %0d expected 36", st_busy); end
    endtask

    task automatic test_abort;
        loopback = 1'b1;
        start_xfer(8'h0F, MODE2, 1'b0, 2'd0, 8'd1);
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (ss_n !== 4'hF) begin n_fail++; $display("FAIL abort_ss_n: got %b expected 1111", ss_n); end
        if (sclk !== 1'b1) begin n_fail++; $display("FAIL abort_sclk: got %b expected 1", sclk); end
        if (mosi !== 1'b0) begin n_fail++; $display("FAIL abort_mosi: got %b expected 0", mosi); end
        watch(50, 4'hF, 1'b0, -1);
        n_checks += 2;
        if (st_done != 0)     begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", st_done); end
        if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL abort_rx_hold: got %02h expected a5", rx_data); end
    endtask

    task automatic test_back_to_back;
        int total_done;
        loopback = 1'b1;
        sb.push_back(8'hC3);
        sb.push_back(8'h5A);
        start_xfer(8'hC3, MODE0, 1'b0, 2'd1, 8'd1);
        watch(60, 4'b1101, 1'b1, -1);
        total_done = st_done;
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_busy: got %b expected 0", busy); end
        if (ss_n !== 4'hF) begin n_fail++; $display("FAIL b2b_ss_gap: got %b expected 1111", ss_n); end
        tx_data = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
        watch(60, 4'b1101, 1'b0, -1);
        total_done += st_done;
        n_checks += 2;
        if (total_done != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", total_done); end
        if (st_busy != 36)   begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 36", st_busy); end
    endtask

    task automatic test_async_reset;
        loopback = 1'b1;
        start_xfer(8'h99, MODE3, 1'b0, 2'd3, 8'd3);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (sclk !== 1'b0)     begin n_fail++; $display("FAIL arst_sclk: got %b expected 0", sclk); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
        if (ss_n !== 4'hF)     begin n_fail++; $display("FAIL arst_ss_n: got %b expected 1111", ss_n); end
        if (mosi !== 1'b0)     begin n_fail++; $display("FAIL arst_mosi: got %b expected 0", mosi); end
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL arst_rx: got %02h expected 00", rx_data); end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(8'h66);
        start_xfer(8'h66, MODE0, 1'b0, 2'd0, 8'd1);
        watch(60, 4'b1110, 1'b0, -1);
        n_checks += 2;
        if (st_done != 1)  begin n_fail++; $display("FAIL arst_fresh_done: got %0d expected 1", st_done); end
        if (st_busy != 36) begin n_fail++; $display("FAIL arst_fresh_busy: got %0d expected 36", st_busy); end
    endtask

    initial begin
        m_pol = 1'b0; m_pha = 1'b0;
        test_reset();
        test_mode0_loopback();
        test_mode3_lsb();
        test_slave_sel();
        test_abort();
        test_back_to_back();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
